// File: rtl/mc_mem_pkg.sv
// Shared types and helpers for the multi-cycle controller memory interface:
// size codes, error codes, FSM encoding and store lane steering.
package mc_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_CONFLICT = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // The reserved size code 11 is handled like a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            default: mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = 4'b0011 << offset;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mc_mem_if_if.sv
// Word-wide external memory bus with a req/ack handshake.
// master = mc_mem_if side, slave = memory side.
interface mc_mem_if_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);

    logic                  mem_req;
    logic                  mem_sel;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req,
        output mem_sel,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_sel,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );

endinterface

// File: rtl/mc_mem_if_load_align.sv
// Load alignment: shift the fetched word down to the addressed lane and
// sign- or zero-extend bytes and halves. Purely combinational.
module mc_load_align
    import mc_mem_pkg::*;
(
    input  logic [31:0] rdata_in,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;
    logic        sign;

    always_comb begin
        shifted   = rdata_in >> {offset, 3'b000};
        sign      = 1'b0;
        rdata_out = shifted;
        case (size)
            SZ_BYTE: begin
                sign      = ~load_unsigned & shifted[7];
                rdata_out = {{24{sign}}, shifted[7:0]};
            end
            SZ_HALF: begin
                sign      = ~load_unsigned & shifted[15];
                rdata_out = {{16{sign}}, shifted[15:0]};
            end
            default: rdata_out = shifted;
        endcase
    end

endmodule

// File: rtl/mc_mem_if.sv
// Memory-interface stage behind the multi-cycle controller: checks each
// request, runs the req/ack handshake and returns aligned data with done.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | waiting for mem_r/mem_w; the only state that samples them
//   ST_ACCESS | mem_req high, waiting for mem_ack or the timeout
//   ST_RESP   | done strobe (plus err when err_code != 0), back to idle
module mc_mem_if
    import mc_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_d_mem,
    input  logic                  mem_r,
    input  logic                  mem_w,
    input  logic [1:0]            mem_size,
    input  logic                  load_unsigned,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic [1:0]            err_code,
    mc_mem_if_if.master           mem
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_q, req_d;
    logic                  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            err_code_q, err_code_d;

    logic [1:0]            eff_size;
    logic                  misaligned;
    logic [31:0]           align_data;

    // Instruction fetches are always full words regardless of mem_size.
    assign eff_size   = i_d_mem ? mem_size : SZ_WORD;
    assign misaligned = is_misaligned(eff_size, addr[1:0]);

    mc_load_align u_align (
        .rdata_in      (mem.mem_rdata),
        .offset        (off_q),
        .size          (size_q),
        .load_unsigned (uns_q),
        .rdata_out     (align_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        size_d     = size_q;
        uns_d      = uns_q;
        rdata_d    = rdata_q;
        err_code_d = err_code_q;

        case (state_q)
            ST_IDLE: begin
                if (mem_r && mem_w) begin
                    err_code_d = ERR_CONFLICT;
                    state_d    = ST_RESP;
                end else if (mem_r || mem_w) begin
                    if (misaligned) begin
                        err_code_d = ERR_MISALIGN;
                        state_d    = ST_RESP;
                    end else begin
                        err_code_d = ERR_NONE;
                        addr_d     = {addr[ADDR_WIDTH-1:2], 2'b00};
                        be_d       = mem_w ? store_be(eff_size, addr[1:0]) : 4'b1111;
                        wdata_d    = mem_w ? store_lanes(eff_size, wdata) : '0;
                        we_d       = mem_w;
                        sel_d      = i_d_mem;
                        off_d      = addr[1:0];
                        size_d     = eff_size;
                        uns_d      = load_unsigned;
                        cnt_d      = '0;
                        req_d      = 1'b1;
                        state_d    = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack in the last allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q) begin
                        rdata_d = align_data;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = 1'b0;
                    rdata_d    = '0;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            sel_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            rdata_q    <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            rdata_q    <= rdata_d;
            err_code_q <= err_code_d;
        end
    end

    assign done          = (state_q == ST_RESP);
    assign err           = done && (err_code_q != ERR_NONE);
    assign err_code      = err_code_q;
    assign busy          = (state_q != ST_IDLE);
    assign rdata         = rdata_q;

    assign mem.mem_req   = req_q;
    assign mem.mem_sel   = sel_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mc_mem_if.sv
// Bench for mc_mem_if: directed cases with literal expectations followed by
// random transactions, all checked cycle by cycle against a transaction model.
module tb_mc_mem_if;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_d_mem = 1'b0;
    logic        mem_r = 1'b0;
    logic        mem_w = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic        load_unsigned = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        done, busy, err;
    logic [1:0]  err_code;

    mc_mem_if_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    mc_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_d_mem       (i_d_mem),
        .mem_r         (mem_r),
        .mem_w         (mem_w),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .wdata         (wdata),
        .rdata         (rdata),
        .done          (done),
        .busy          (busy),
        .err           (err),
        .err_code      (err_code),
        .mem           (mem_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model of the transaction in flight (cycle numbers are absolute).
    bit          t_active = 1'b0;
    bit          t_has_req = 1'b0;
    int          t_c0 = 0, t_last = -1, t_done = -1;
    logic [1:0]  t_err = 2'b00;
    logic [31:0] t_new_rdata = '0, prev_rdata = '0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [3:0]  e_be = '0;
    bit          e_we = 1'b0, e_sel = 1'b0;

    // Observations taken when done is seen, used by the literal checks.
    int          obs_done_rel = -1;
    int          obs_req_cycles = 0;
    logic [1:0]  obs_err_code = '0;
    logic        obs_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input int off, input int sz, input bit uns);
        logic [31:0] s, v;
        s = word >> (8 * off);
        if (sz == 0) begin
            v = s % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = s % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = s;
        end
        return v;
    endfunction

    function automatic logic [3:0] model_be(input int sz, input int off);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_lanes(input int sz, input logic [31:0] d);
        if (sz == 0) return (d % 256) * 32'h0101_0101;
        if (sz == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    // Compare process: every cycle, a little after the rising edge.
    always @(posedge clk) begin
        bit          er, ed, eb;
        logic [31:0] erd;
        #2;
        if (chk_en) begin
            er  = t_active && t_has_req && (cyc >= t_c0 + 1) && (cyc <= t_last);
            ed  = t_active && (cyc == t_done);
            eb  = t_active && (cyc >= t_c0 + 1) && (cyc <= t_done);
            erd = (t_active && cyc >= t_done) ? t_new_rdata : prev_rdata;
            chk("mem_req", mem_bus.mem_req, er);
            chk("done", done, ed);
            chk("busy", busy, eb);
            chk("err", err, ed && (t_err != 2'b00));
            chk("rdata", rdata, erd);
            if (ed) chk("err_code", err_code, t_err);
            if (er) begin
                chk("mem_addr", mem_bus.mem_addr, e_addr);
                chk("mem_be", mem_bus.mem_be, e_be);
                chk("mem_we", mem_bus.mem_we, e_we);
                chk("mem_sel", mem_bus.mem_sel, e_sel);
                if (e_we) chk("mem_wdata", mem_bus.mem_wdata, e_wdata);
            end
            if (done) begin
                obs_done_rel = cyc - t_c0;
                obs_err_code = err_code;
                obs_err      = err;
            end
            if (mem_bus.mem_req) obs_req_cycles++;
        end
    end

    // rw: 0 = read, 1 = write, 2 = both strobes. k: ack cycle after the
    // request (k > TIMEOUT means no ack). abort_at != 0 asserts rst then.
    task automatic do_txn(input int rw, input bit idm, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input int k,
                          input logic [31:0] word, input int abort_at);
        int esz, off;
        bit mis;
        esz = idm ? int'(sz) : 2;
        off = int'(a % 4);
        mis = (esz == 1 && (a % 2) != 0) || (esz >= 2 && off != 0);
        if (t_active) prev_rdata = t_new_rdata;
        t_active       = 1'b1;
        t_c0           = cyc;
        obs_done_rel   = -1;
        obs_req_cycles = 0;
        obs_err_code   = 2'b00;
        obs_err        = 1'b0;
        if (rw == 2 || mis) begin
            t_has_req   = 1'b0;
            t_err       = (rw == 2) ? 2'b10 : 2'b01;
            t_last      = -1;
            t_done      = cyc + 1;
            t_new_rdata = prev_rdata;
        end else begin
            t_has_req = 1'b1;
            if (k <= TIMEOUT) begin
                t_last      = cyc + k;
                t_err       = 2'b00;
                t_new_rdata = (rw == 0) ? model_load(word, off, esz, uns) : prev_rdata;
            end else begin
                t_last      = cyc + TIMEOUT;
                t_err       = 2'b11;
                t_new_rdata = '0;
            end
            t_done = t_last + 1;
        end
        e_addr  = a & 32'hFFFF_FFFC;
        e_be    = (rw == 1) ? model_be(esz, off) : 4'hF;
        e_wdata = model_lanes(esz, wd);
        e_we    = (rw == 1);
        e_sel   = idm;

        i_d_mem = idm; mem_r = (rw != 1); mem_w = (rw != 0);
        mem_size = sz; load_unsigned = uns; addr = a; wdata = wd;
        mem_bus.mem_ack = 1'b0;
        @(negedge clk);
        while (cyc <= t_done) begin
            if (abort_at != 0 && cyc == t_c0 + abort_at) begin
                rst = 1'b1;
                chk_en = 1'b0;
                #1;
                chk("rst_mem_req", mem_bus.mem_req, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                t_active = 1'b0;
                prev_rdata = '0;
                mem_r = 1'b0; mem_w = 1'b0; mem_bus.mem_ack = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_hold_done", done, 1'b0);
                end
                rst = 1'b0;
                chk_en = 1'b1;
                return;
            end
            // Strobes outside IDLE must be ignored, so drive noise on them.
            i_d_mem = 1'($urandom); mem_r = 1'($urandom); mem_w = 1'($urandom);
            mem_size = 2'($urandom); load_unsigned = 1'($urandom);
            addr = $urandom; wdata = $urandom;
            mem_bus.mem_ack   = t_has_req && (k <= TIMEOUT) && (cyc == t_c0 + k);
            mem_bus.mem_rdata = mem_bus.mem_ack ? word : $urandom;
            @(negedge clk);
        end
        mem_r = 1'b0; mem_w = 1'b0; mem_bus.mem_ack = 1'b0;
    endtask

    initial begin
        int          rw, k;
        bit          idm, uns;
        logic [1:0]  sz;
        logic [31:0] a;

        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_done", done, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 1'b0);
        chk("reset_err_code", err_code, 2'b00);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_mem_req", mem_bus.mem_req, 1'b0);
        chk("reset_mem_addr", mem_bus.mem_addr, 32'h0);
        chk("reset_mem_be", mem_bus.mem_be, 4'h0);
        chk("reset_mem_we", mem_bus.mem_we, 1'b0);
        chk("reset_mem_sel", mem_bus.mem_sel, 1'b0);
        chk("reset_mem_wdata", mem_bus.mem_wdata, 32'h0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Word fetch: size is ignored in instruction space.
        do_txn(0, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 3, 32'h00A0_0093, 0);
        chk("fetch_rdata", rdata, 32'h00A0_0093);
        chk("fetch_addr", mem_bus.mem_addr, 32'h100);
        chk("fetch_be", mem_bus.mem_be, 4'hF);
        chk("fetch_done_cycle", obs_done_rel, 4);
        chk("fetch_err", obs_err, 1'b0);

        do_txn(0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h0, 2, 32'h80FF_FFFF, 0);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        do_txn(0, 1'b1, 2'b00, 1'b1, 32'h203, 32'h0, 2, 32'h80FF_FFFF, 0);
        chk("lbu_rdata", rdata, 32'h0000_0080);

        do_txn(1, 1'b1, 2'b01, 1'b0, 32'h302, 32'h1234_ABCD, 1, 32'h0, 0);
        chk("sh_we", mem_bus.mem_we, 1'b1);
        chk("sh_be", mem_bus.mem_be, 4'b1100);
        chk("sh_wdata", mem_bus.mem_wdata, 32'hABCD_ABCD);
        chk("sh_addr", mem_bus.mem_addr, 32'h300);
        chk("sh_rdata_held", rdata, 32'h0000_0080);

        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h401, 32'h0, 1, 32'h0, 0);
        chk("mis_err_code", obs_err_code, 2'b01);
        chk("mis_done_cycle", obs_done_rel, 1);
        chk("mis_req_cycles", obs_req_cycles, 0);
        chk("mis_err", obs_err, 1'b1);

        do_txn(2, 1'b1, 2'b10, 1'b0, 32'h500, 32'h0, 1, 32'h0, 0);
        chk("conflict_err_code", obs_err_code, 2'b10);
        chk("conflict_done_cycle", obs_done_rel, 1);

        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h600, 32'h0, TIMEOUT + 1, 32'h0, 0);
        chk("timeout_err_code", obs_err_code, 2'b11);
        chk("timeout_req_cycles", obs_req_cycles, 4);
        chk("timeout_done_cycle", obs_done_rel, 5);
        chk("timeout_rdata", rdata, 32'h0);
        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h604, 32'h0, 4, 32'hDEAD_BEEF, 0);
        chk("after_timeout_rdata", rdata, 32'hDEAD_BEEF);
        chk("after_timeout_err", obs_err, 1'b0);

        do_txn(0, 1'b1, 2'b10, 1'b0, 32'h700, 32'h0, TIMEOUT + 1, 32'h0, 2);
        chk("after_rst_rdata", rdata, 32'h0);
        @(negedge clk);
        do_txn(0, 1'b1, 2'b01, 1'b1, 32'h702, 32'h0, 2, 32'hBEEF_1234, 0);
        chk("after_rst_read", rdata, 32'h0000_BEEF);
        chk("after_rst_done_cycle", obs_done_rel, 3);

        for (int n = 0; n < 300; n++) begin
            rw  = ($urandom % 10 == 0) ? 2 : int'($urandom % 2);
            idm = 1'($urandom);
            sz  = 2'($urandom_range(2, 0));
            uns = 1'($urandom);
            a   = $urandom;
            if ($urandom % 2 == 1) a[1:0] = 2'b00;
            k   = int'($urandom_range(TIMEOUT + 1, 1));
            do_txn(rw, idm, sz, uns, a, $urandom, k, $urandom, 0);
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
